// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared definitions for the load/store access unit.
//   - req_op encodings (OP_*)
//   - FSM state enum (S_IDLE/S_RD/S_WR/S_RESP)
//   - access size enum and op decode helpers (size, store, signed, misaligned)
package mem_access_pkg;

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LW  = 3'd2;
    localparam logic [2:0] OP_SB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_LHU = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    function automatic size_e op_size(input logic [2:0] op);
        case (op)
            OP_LB, OP_SB, OP_LBU: op_size = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: op_size = SZ_HALF;
            default:              op_size = SZ_WORD;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [2:0] op);
        op_is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Meaningful for loads only: LB/LH/LW sit in op[2]=0, unsigned loads in op[2]=1.
    function automatic logic op_signed(input logic [2:0] op);
        op_signed = ~op[2];
    endfunction

    function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] off);
        case (op_size(op))
            SZ_HALF: op_misaligned = off[0];
            SZ_WORD: op_misaligned = |off;
            default: op_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_lane.sv
// mem_lane_unit: purely combinational byte-lane logic for the access unit.
//   old_word  in  32  word read from memory
//   wdata     in  32  store data, right-justified
//   byte_off  in  2   addr[1:0], little-endian lane select
//   size      in  2   size_e encoding (byte/half/word)
//   is_signed in  1   sign-extend loads
//   merged    out 32  old_word with the addressed lane(s) replaced by wdata
//   extracted out 32  addressed lane(s) of old_word, sign/zero extended
module mem_lane_unit
    import mem_access_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  byte_off,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] merged,
    output logic [31:0] extracted
);

    localparam int NUM_LANES = 4;

    logic [NUM_LANES-1:0][7:0] byte_merge;
    logic [7:0]                byte_sel;
    logic [15:0]               half_sel;

    // Byte store: each lane either keeps its old byte or takes wdata[7:0].
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign byte_merge[g] = (byte_off == 2'(g)) ? wdata[7:0] : old_word[8*g +: 8];
    end

    assign byte_sel = old_word[{byte_off, 3'b000} +: 8];
    assign half_sel = byte_off[1] ? old_word[31:16] : old_word[15:0];

    always_comb begin
        merged    = wdata;
        extracted = old_word;
        case (size)
            SZ_BYTE: begin
                merged    = byte_merge;
                extracted = {{24{is_signed & byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                merged    = byte_off[1] ? {wdata[15:0], old_word[15:0]}
                                        : {old_word[31:16], wdata[15:0]};
                extracted = {{16{is_signed & half_sel[15]}}, half_sel};
            end
            default: begin
                merged    = wdata;
                extracted = old_word;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store access unit in front of a word-wide data memory
// (combinational read, write committed on the falling edge of a write cycle).
//   clock_in, rst                        clock, async active-high reset
//   req_valid/req_ready/req_op/req_addr/req_wdata   request handshake
//   resp_valid/resp_rdata/resp_err       one-cycle response pulse
//   mem_addr/mem_writeData/mem_memRead/mem_memWrite/mem_readData  memory port
// Flow: misaligned -> RESP; load -> RD -> RESP; SW -> WR -> RESP;
//       SB/SH -> RD -> WR -> RESP (read-modify-write).
// Optional: `define MEM_ACCESS_RANGE_CHECK_EN rejects word addresses
//           >= DEPTH_WORDS with resp_err (checked after alignment).
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64
) (
    input  logic        clock_in,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_writeData,
    output logic        mem_memRead,
    output logic        mem_memWrite,
    input  logic [31:0] mem_readData
);

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_q, word_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic [31:0] lane_merged;
    logic [31:0] lane_extracted;
    logic        req_reject;

    mem_lane_unit u_lane (
        .old_word  (mem_readData),
        .wdata     (wdata_q),
        .byte_off  (addr_q[1:0]),
        .size      (op_size(op_q)),
        .is_signed (op_signed(op_q)),
        .merged    (lane_merged),
        .extracted (lane_extracted)
    );

`ifdef MEM_ACCESS_RANGE_CHECK_EN
    assign req_reject = op_misaligned(req_op, req_addr[1:0]) ||
                        (req_addr[31:2] >= 30'(DEPTH_WORDS));
`else
    logic unused_depth;
    assign unused_depth = ^DEPTH_WORDS;
    assign req_reject   = op_misaligned(req_op, req_addr[1:0]);
`endif

    // Ready is held low while reset is asserted even though state is already IDLE.
    assign req_ready     = !rst && (state_q == S_IDLE);
    assign mem_memRead   = (state_q == S_RD);
    assign mem_memWrite  = (state_q == S_WR);
    assign mem_addr      = {addr_q[31:2], 2'b00};
    assign mem_writeData = word_q;
    assign resp_valid    = resp_valid_q;
    assign resp_err      = resp_err_q;
    assign resp_rdata    = resp_rdata_q;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        word_d       = word_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (req_reject) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (req_op == OP_SW) begin
                        word_d  = req_wdata;
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                if (op_is_store(op_q)) begin
                    word_d  = lane_merged;
                    state_d = S_WR;
                end else begin
                    word_d       = mem_readData;
                    resp_rdata_d = lane_extracted;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end
            end
            S_WR: begin
                resp_valid_d = 1'b1;
                state_d      = S_RESP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_in or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= 3'd0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            word_q       <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            word_q       <= word_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_writeData;
    logic        mem_memRead;
    logic        mem_memWrite;
    logic [31:0] mem_readData;

    logic [31:0] mem [0:63];

    int checks = 0;
    int errors = 0;

    // results of the last run_req
    logic [31:0] r_rdata, r_waddr, r_wdata, r_raddr;
    logic        r_err, r_seen;
    int          r_lat, r_rd, r_wr;

    always #5 clk = ~clk;

    mem_access_unit #(.DEPTH_WORDS(64)) dut (
        .clock_in      (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .mem_addr      (mem_addr),
        .mem_writeData (mem_writeData),
        .mem_memRead   (mem_memRead),
        .mem_memWrite  (mem_memWrite),
        .mem_readData  (mem_readData)
    );

    // Behavioural memory: combinational read, write on falling edge.
    assign mem_readData = (mem_addr[31:8] == 24'h0) ? mem[mem_addr[7:2]] : 32'h0;
    always @(negedge clk)
        if (mem_memWrite && mem_addr[31:8] == 24'h0) mem[mem_addr[7:2]] <= mem_writeData;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request and observe the transaction at every falling edge
    // until the response pulse (bounded to 10 cycles).
    task automatic run_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
        int edges;
        r_rd = 0; r_wr = 0; r_lat = 0; r_seen = 1'b0;
        r_rdata = 32'hx; r_err = 1'bx; r_waddr = 32'hx; r_wdata = 32'hx; r_raddr = 32'hx;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        edges = 1;
        #1 req_valid = 1'b0;
        req_op = 3'd0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_5555;
        repeat (10) begin
            @(negedge clk);
            if (mem_memRead)  begin r_rd++; r_raddr = mem_addr; end
            if (mem_memWrite) begin r_wr++; r_waddr = mem_addr; r_wdata = mem_writeData; end
            if (resp_valid) begin
                r_seen = 1'b1; r_lat = edges; r_rdata = resp_rdata; r_err = resp_err;
                break;
            end
            @(posedge clk);
            edges++;
        end
        chk("resp_seen", 32'(r_seen), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
        #12;
        chk("rst_ready",  32'(req_ready),    32'd0);
        chk("rst_rvalid", 32'(resp_valid),   32'd0);
        chk("rst_rdata",  resp_rdata,        32'd0);
        chk("rst_err",    32'(resp_err),     32'd0);
        chk("rst_rd",     32'(mem_memRead),  32'd0);
        chk("rst_wr",     32'(mem_memWrite), 32'd0);
        chk("rst_addr",   mem_addr,          32'd0);
        chk("rst_wdata",  mem_writeData,     32'd0);
        rst = 1'b0;
        #1 chk("ready_after_rst", 32'(req_ready), 32'd1);

        // SW then LW
        run_req(3'd7, 32'h10, 32'hDEADBEEF);
        chk("sw_lat", r_lat, 2); chk("sw_rd", r_rd, 0); chk("sw_wr", r_wr, 1);
        chk("sw_waddr", r_waddr, 32'h10); chk("sw_wdata", r_wdata, 32'hDEADBEEF);
        chk("sw_err", 32'(r_err), 0); chk("sw_rdata", r_rdata, 0);
        chk("sw_mem", mem[4], 32'hDEADBEEF);
        @(negedge clk) chk("resp_pulse_one_cycle", 32'(resp_valid), 0);
        run_req(3'd2, 32'h10, 32'h0);
        chk("lw_rdata", r_rdata, 32'hDEADBEEF); chk("lw_err", 32'(r_err), 0);
        chk("lw_lat", r_lat, 2); chk("lw_rd", r_rd, 1); chk("lw_wr", r_wr, 0);

        // Sub-word stores via read-modify-write
        mem[5] = 32'h11223344;
        run_req(3'd3, 32'h17, 32'h000000A5);
        chk("sb_lat", r_lat, 3); chk("sb_rd", r_rd, 1); chk("sb_wr", r_wr, 1);
        chk("sb_waddr", r_waddr, 32'h14); chk("sb_mem", mem[5], 32'hA5223344);
        run_req(3'd6, 32'h14, 32'h0000BEEF);
        chk("sh_lat", r_lat, 3); chk("sh_mem", mem[5], 32'hA522BEEF);

        // Sub-word loads with extension
        run_req(3'd0, 32'h17, 0); chk("lb_17",  r_rdata, 32'hFFFFFFA5);
        run_req(3'd4, 32'h17, 0); chk("lbu_17", r_rdata, 32'h000000A5);
        run_req(3'd1, 32'h16, 0); chk("lh_16",  r_rdata, 32'hFFFFA522);
        run_req(3'd5, 32'h14, 0); chk("lhu_14", r_rdata, 32'h0000BEEF);
        run_req(3'd0, 32'h14, 0); chk("lb_14",  r_rdata, 32'hFFFFFFEF);
        run_req(3'd4, 32'h15, 0); chk("lbu_15", r_rdata, 32'h000000BE);
        run_req(3'd1, 32'h14, 0); chk("lh_14",  r_rdata, 32'hFFFFBEEF);

        // Misaligned requests
        run_req(3'd2, 32'h06, 0);
        chk("lw6_err", 32'(r_err), 1); chk("lw6_lat", r_lat, 1); chk("lw6_rdata", r_rdata, 0);
        chk("lw6_rd", r_rd, 0); chk("lw6_wr", r_wr, 0);
        run_req(3'd6, 32'h05, 32'h1234);
        chk("sh5_err", 32'(r_err), 1); chk("sh5_lat", r_lat, 1); chk("sh5_rdata", r_rdata, 0);
        chk("sh5_rd", r_rd, 0); chk("sh5_wr", r_wr, 0); chk("sh5_mem", mem[1], 0);
        run_req(3'd5, 32'h13, 0);
        chk("lhu13_err", 32'(r_err), 1);

        // Range check
        run_req(3'd2, 32'h100, 0);
`ifdef MEM_ACCESS_RANGE_CHECK_EN
        chk("rng_err", 32'(r_err), 1); chk("rng_lat", r_lat, 1); chk("rng_rd", r_rd, 0);
`else
        chk("rng_err", 32'(r_err), 0); chk("rng_lat", r_lat, 2); chk("rng_rd", r_rd, 1);
        chk("rng_raddr", r_raddr, 32'h100);
`endif

        // Reset during WR of an SB: write must be suppressed, no response
        mem[8] = 32'hCAFEF00D;
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd3; req_addr = 32'h21; req_wdata = 32'h77;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 chk("abort_in_wr", 32'(mem_memWrite), 1);
        rst = 1'b1;
        #1 chk("abort_wr_drop", 32'(mem_memWrite), 0);
        chk("abort_ready_low", 32'(req_ready), 0);
        begin
            int rv = 0;
            repeat (3) begin @(negedge clk); if (resp_valid) rv++; end
            rst = 1'b0;
            #1 chk("abort_ready", 32'(req_ready), 1);
            repeat (3) begin @(negedge clk); if (resp_valid || mem_memRead || mem_memWrite) rv++; end
            chk("abort_no_resp", rv, 0);
        end
        chk("abort_mem", mem[8], 32'hCAFEF00D);

        // Unit still works after the abort
        run_req(3'd4, 32'h21, 0); chk("post_abort_lbu", r_rdata, 32'h000000F0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store access unit placed between the single-cycle datapath's load/store decode and the word-wide data memory (combinational read, write on falling clock edge). It is the initiator side of the memory's addr/writeData/memRead/memWrite/readData interface. It accepts byte, halfword and word loads and stores, runs read-modify-write for sub-word stores, and returns sign- or zero-extended load data through a valid/ready request and valid-pulse response handshake.

## Interface
- DEPTH_WORDS, 64: number of 32-bit words behind the memory port; used by the range check only.
- clock_in  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_op  in  3  0 LB, 1 LH, 2 LW, 3 SB, 4 LBU, 5 LHU, 6 SH, 7 SW.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified for SB/SH.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid; misaligned or out-of-range.
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
- mem_writeData  out  32  word to write.
- mem_memRead  out  1  read strobe.
- mem_memWrite  out  1  write strobe; the memory commits on the falling edge of this cycle.
- mem_readData  in  32  combinational read data.

## Operation
- Handshake: request latched on rising edge with req_valid && req_ready. req_op, req_addr and req_wdata are held in registers. Response has no backpressure.
- States: IDLE, RD, WR, RESP. Strobes are decoded from the state register only.
  - IDLE → RESP on a misaligned request (LH/LHU/SH with addr[0]≠0, LW/SW with addr[1:0]≠0). No strobe is issued.
  - Loads: IDLE → RD → RESP.
  - SW: IDLE → WR → RESP.
  - SB/SH: IDLE → RD → WR → RESP (read-modify-write).
  - RESP → IDLE unconditionally.
- RD: mem_memRead=1. mem_readData is captured into the word register at the closing rising edge.
- WR: mem_memWrite=1. mem_writeData comes from the word register. For SW, the word register holds req_wdata. For SB/SH, it holds the captured word with the addressed lane replaced.
- Byte lanes are little-endian: addr[1:0]=0 selects bits 7:0. A halfword at addr[1]=1 selects bits 31:16.
- Loads: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- mem_addr, mem_writeData and strobes are stable for the whole RD/WR cycle. Strobes are 0 in IDLE and RESP.

## Timing
- Reset values: req_ready=1 after rst falls (0 while rst is high), resp_valid=0, resp_rdata=0, resp_err=0, mem_memRead=0, mem_memWrite=0, mem_addr=0, mem_writeData=0, state=IDLE.
- Latency, counted as rising edges from accept to the start of the resp_valid cycle: error 1, load 2, SW 2, SB/SH 3.
- Throughput: one request every latency+1 cycles. No accept occurs in RESP.
- Reset mid-operation: state and strobes clear asynchronously. If rst rises during WR before the falling edge, no write reaches memory. No response is produced for an aborted request.
- req_valid dropping after accept has no effect. Request inputs are ignored outside IDLE.

## Configuration
- MEM_ACCESS_RANGE_CHECK_EN defined: a request with addr[31:2] ≥ DEPTH_WORDS goes straight to RESP with resp_err=1 and no strobe. This check is applied after the alignment check.
- Not defined: no range check. The address is forwarded unchanged, and only misalignment sets resp_err.

## Structure
- Package mem_access_pkg holds:
  - the req_op encodings as named constants;
  - the state enum (IDLE, RD, WR, RESP);
  - the helper constants for size (byte/half/word) and the signed flag (op[2]=0 for loads).
- Sub-module mem_lane_unit, purely combinational, with two functions:
  - store merge (old word, data, addr[1:0], size → new word);
  - load extract (word, addr[1:0], size, signed → result).
- mem_access_unit holds the FSM and the registers.

## Test plan
- SW 0x10 ← 0xDEADBEEF: one WR cycle with mem_addr=0x10, then resp_valid 2 edges after accept. A following LW 0x10 returns 0xDEADBEEF with resp_err=0.
- Word 0x14 = 0x11223344, SB 0x17 data 0x000000A5: RD then WR cycle, and the memory word becomes 0xA5223344. Then SH 0x14 data 0xBEEF gives 0xA522BEEF.
- On 0xA522BEEF at 0x14:
  - LB 0x17 → 0xFFFFFFA5;
  - LBU 0x17 → 0x000000A5;
  - LH 0x16 → 0xFFFFA522;
  - LHU 0x14 → 0x0000BEEF.
- LW 0x06 and SH 0x05: resp_err=1 on the edge after accept, resp_rdata=0, mem_memRead and mem_memWrite never asserted.
- SB in progress: assert rst during WR while clock_in is high. mem_memWrite falls immediately, the target word is unchanged, no resp_valid is produced, and req_ready=1 after release.
- With MEM_ACCESS_RANGE_CHECK_EN and DEPTH_WORDS=64: LW 0x100 gives resp_err=1 with no strobe. Without the macro, the same request produces one RD cycle with mem_addr=0x100.
